// File: rtl/reset_sequencer_if.sv
// Avalon-MM slave bus bundle for the reset sequencer register file.
// The master modport drives the request side and the slave returns read data.
interface reset_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES active-low resets one at a time, stage 0 first, with a programmable gap.
// A restart comes from a CONTROL write or from a rising edge on req_in.
module reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DELAY = 100
) (
    input  logic                  clk,
    input  logic                  reset_n,
    reset_sequencer_if.slave      bus,
    input  logic                  req_in,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  done,
    output logic                  done_pulse
);
    localparam logic [1:0] S_ASSERT = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0]       LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] DLY_RST    = CNT_W'(DEFAULT_DELAY);

    logic [1:0]            r_state;
    logic [NUM_STAGES-1:0] r_rst_n;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_delay;
    logic [3:0]            r_stage;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_done_pulse;
    logic                  r_req_q;

    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_delay_wr;
    logic        w_restart;
    logic        w_cnt_zero;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_ctrl_wr  = w_wr && (bus.address == 3'd0);
    assign w_delay_wr = w_wr && (bus.address == 3'd2);
    assign w_restart  = (w_ctrl_wr & bus.writedata[1]) | (req_in & ~r_req_q);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_unused   = &{1'b0, bus.writedata};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_ASSERT;
            r_rst_n      <= '0;
            r_cnt        <= DLY_RST;
            r_delay      <= DLY_RST;
            r_stage      <= 4'd0;
            r_hold       <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_req_q      <= 1'b0;
        end else begin
            r_req_q      <= req_in;
            r_done_pulse <= 1'b0;
            if (w_ctrl_wr)  r_hold  <= bus.writedata[0];
            if (w_delay_wr) r_delay <= bus.writedata[CNT_W-1:0];

            // Restart outranks any release due on the same edge.
            if (w_restart) begin
                r_state <= S_ASSERT;
                r_rst_n <= '0;
                r_cnt   <= r_delay;
                r_stage <= 4'd0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_ASSERT: begin
                        if (r_hold) begin
                            r_cnt <= r_delay;
                        end else if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_rst_n[0] <= 1'b1;
                            r_cnt      <= r_delay;
                            if (NUM_STAGES == 1) begin
                                r_state      <= S_DONE;
                                r_done       <= 1'b1;
                                r_done_pulse <= 1'b1;
                                r_stage      <= 4'd0;
                            end else begin
                                r_state <= S_WAIT;
                                r_stage <= 4'd1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_STAGES; i++)
                                if (r_stage == 4'(i)) r_rst_n[i] <= 1'b1;
                            r_cnt <= r_delay;
                            // Stage index returns to 0 once idle so STATUS reads a clean DONE word.
                            if (r_stage == LAST_STAGE) begin
                                r_state      <= S_DONE;
                                r_done       <= 1'b1;
                                r_done_pulse <= 1'b1;
                                r_stage      <= 4'd0;
                            end else begin
                                r_stage <= r_stage + 4'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_rst_n <= '1;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state <= S_ASSERT;
                        r_rst_n <= '0;
                        r_cnt   <= r_delay;
                        r_stage <= 4'd0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            3'd0: w_rdata[0] = r_hold;
            3'd1: begin
                w_rdata[NUM_STAGES-1:0] = r_rst_n;
                w_rdata[8]              = r_done;
                w_rdata[18:16]          = {1'b0, r_state};
                w_rdata[27:24]          = r_stage;
            end
            3'd2: w_rdata[CNT_W-1:0] = r_delay;
            3'd3: w_rdata[CNT_W-1:0] = r_cnt;
            default: w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;
    assign rst_out_n    = r_rst_n;
    assign done         = r_done;
    assign done_pulse   = r_done_pulse;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected values go into a scoreboard queue
// and are popped and asserted against DUT outputs sampled on the falling edge.
module tb_reset_sequencer;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_in = 1'b0;
    logic [NS-1:0] rst_out_n;
    logic          done;
    logic          done_pulse;

    reset_sequencer_if bus();

    reset_sequencer #(.NUM_STAGES(NS), .CNT_W(16), .DEFAULT_DELAY(100)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .req_in     (req_in),
        .rst_out_n  (rst_out_n),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_exp[$];
    string       q_tag[$];

    function automatic logic [31:0] ev(input int c, input int kind, input logic [3:0] v);
        return {16'(c), 8'(kind), 4'h0, v};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (q_exp.size() == 0) begin
            e = ~obs;
            t = "scoreboard_empty";
        end else begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
        end
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_chk(obs);
    endtask

    task automatic sb_drained(input string tag);
        checks++;
        assert (q_exp.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d pending expected 0", tag, q_exp.size());
            q_exp.delete();
            q_tag.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick();
        bus.write_n    = 1'b1;
        bus.chipselect = 1'b0;
        bus.writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        v = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_rst(input logic [3:0] pat, input int budget, input string tag, output int n);
        n = 0;
        while (rst_out_n !== pat && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(rst_out_n === pat), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [3:0]  prev;
        int          n, m, nz;
        logic [3:0]  seq [5];
        seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h3; seq[3] = 4'h7; seq[4] = 4'hF;

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) tick();

        // Reset values
        check("rst_out_n_reset", 32'(rst_out_n), 32'h0);
        check("done_reset", 32'(done), 32'h0);
        check("done_pulse_reset", 32'(done_pulse), 32'h0);
        rd(3'd0, v); check("control_reset", v, 32'h0);
        rd(3'd1, v); check("status_reset", v, 32'h0);
        rd(3'd2, v); check("delay_reset", v, 32'd100);
        rd(3'd3, v); check("count_reset", v, 32'd100);

        // Default sequence: releases at 101/202/303/404, single done_pulse at 404
        push("t1_rel0", ev(101, 0, 4'h1));
        push("t1_rel1", ev(202, 0, 4'h3));
        push("t1_rel2", ev(303, 0, 4'h7));
        push("t1_rel3", ev(404, 0, 4'hF));
        push("t1_pulse", ev(404, 1, 4'h0));
        reset_n = 1'b1;
        prev = 4'h0;
        for (int c = 1; c <= 420; c++) begin
            tick();
            if (rst_out_n !== prev) pop_chk(ev(c, 0, rst_out_n));
            prev = rst_out_n;
            if (done_pulse === 1'b1) pop_chk(ev(c, 1, 4'h0));
        end
        sb_drained("t1_events");
        check("t1_done", 32'(done), 32'h1);
        rd(3'd1, v); check("t1_status", v, 32'h0002010F);

        // DELAY=0: one stage per cycle, COUNT stays 0
        wr(3'd2, 32'd0);
        for (int i = 0; i < 5; i++) begin
            push("t2_rst", 32'(seq[i]));
            push("t2_cnt", 32'h0);
        end
        wr(3'd0, 32'h2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            pop_chk(32'(rst_out_n));
            rd(3'd3, v);
            pop_chk(v);
        end
        check("t2_pulse_on", 32'(done_pulse), 32'h1);
        tick();
        check("t2_pulse_off", 32'(done_pulse), 32'h0);
        check("t2_done", 32'(done), 32'h1);

        // HOLD + restart keeps everything asserted
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h3);
        nz = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rst_out_n !== 4'h0) nz++;
        end
        check("t3_held_cycles", 32'(nz), 32'h0);
        rd(3'd1, v); check("t3_state", (v >> 16) & 32'h7, 32'h0);
        rd(3'd0, v); check("t3_hold_rb", v, 32'h1);
        wr(3'd0, 32'h0);
        wait_rst(4'h1, 100, "t3_release_seen", n);
        check("t3_release_latency", 32'(n), 32'd6);

        // req_in held high: exactly one restart
        wr(3'd2, 32'd10);
        wr(3'd0, 32'h2);
        wait_rst(4'h3, 200, "t4_stage1_seen", n);
        check("t4_stage1_latency", 32'(n), 32'd22);
        repeat (3) tick();
        req_in = 1'b1;
        tick();
        check("t4_restart", 32'(rst_out_n), 32'h0);
        push("t4_rel0", ev(11, 0, 4'h1));
        push("t4_rel1", ev(22, 0, 4'h3));
        push("t4_rel2", ev(33, 0, 4'h7));
        push("t4_rel3", ev(44, 0, 4'hF));
        prev = 4'h0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 50) req_in = 1'b0;
            tick();
            if (rst_out_n !== prev) pop_chk(ev(c, 0, rst_out_n));
            prev = rst_out_n;
        end
        sb_drained("t4_events");
        check("t4_done", 32'(done), 32'h1);

        // DELAY change mid-wait only affects the next load
        wr(3'd0, 32'h2);
        wait_rst(4'h1, 50, "t5_stage0_seen", n);
        m = 0;
        rd(3'd3, v);
        while (v !== 32'd5 && m < 20) begin
            tick();
            m++;
            rd(3'd3, v);
        end
        check("t5_cnt5_seen", v, 32'd5);
        wr(3'd2, 32'd20);
        wait_rst(4'h3, 50, "t5_stage1_seen", n);
        check("t5_finish_current", 32'(n + 1), 32'd6);
        wait_rst(4'h7, 100, "t5_stage2_seen", n);
        check("t5_next_step", 32'(n), 32'd21);

        // Restart on the edge a release would happen
        wr(3'd0, 32'h2);
        wait_rst(4'h1, 50, "t6_stage0_seen", n);
        m = 0;
        rd(3'd3, v);
        while (v !== 32'd0 && m < 40) begin
            tick();
            m++;
            rd(3'd3, v);
        end
        check("t6_cnt0_seen", v, 32'd0);
        wr(3'd0, 32'h2);
        check("t6_restart_wins", 32'(rst_out_n), 32'h0);
        rd(3'd1, v); check("t6_status", v, 32'h0);
        rd(3'd3, v); check("t6_count", v, 32'd20);

        // Unused addresses
        for (int a = 4; a < 8; a++) begin
            rd(3'(a), v);
            check("unused_read", v, 32'h0);
        end
        for (int a = 4; a < 8; a++) wr(3'(a), 32'hFFFF_FFFF);
        rd(3'd0, v); check("unused_wr_control", v, 32'h0);
        rd(3'd2, v); check("unused_wr_delay", v, 32'd20);

        // Reset mid-sequence
        wait_rst(4'h1, 50, "t8_stage0_seen", n);
        reset_n = 1'b0;
        tick();
        check("t8_rst_out_n", 32'(rst_out_n), 32'h0);
        check("t8_done", 32'(done), 32'h0);
        rd(3'd1, v); check("t8_status", v, 32'h0);
        rd(3'd2, v); check("t8_delay", v, 32'd100);
        rd(3'd3, v); check("t8_count", v, 32'd100);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
